exec_unit: RTL
==============

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter DATA_W, default 8: width of each register-file entry and of every datapath value.
REQ-002 Parameter RF_DEPTH, default 32: number of register-file entries, addressed by the 5-bit fields.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rstN  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  op/addr1/addr2/addr3 carry an instruction this cycle.
REQ-006 op  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-007 addr1  input  5  source register A index.
REQ-008 addr2  input  5  source register B index.
REQ-009 addr3  input  5  destination register index.
REQ-010 wb_valid  output  1  a result was written back at the last edge.
REQ-011 wb_addr  output  5  destination of that write.
REQ-012 wb_data  output  DATA_W  value written.
REQ-013 wb_carry  output  1  ADD carry-out / SUB borrow of that write; 0 for AND/OR.
REQ-014 retired  output  16  count of written-back instructions.
REQ-015 dbg_addr  input  5  debug read index.
REQ-016 dbg_data  output  DATA_W  combinational RF[dbg_addr], pre-write contents in a write cycle.

Function
REQ-017 Two-stage pipeline, no stalls, no backpressure; accepts one instruction per cycle.
REQ-018 Stage 1 (edge E1, in_valid=1): register op, addr3, operand A, operand B, and set s1_valid; with in_valid=0, clear s1_valid.
REQ-019 Stage 2: result computed combinationally from stage-1 registers; at edge E2 (next edge), if s1_valid, write RF[s1_addr3] and register wb_valid=1, wb_addr, wb_data, wb_carry; else wb_valid=0, wb_addr/wb_data/wb_carry hold.
REQ-020 Latency: instruction presented in cycle n, visible on wb_* in cycle n+2 and in RF from cycle n+2.
REQ-021 Forwarding: at E1, if s1_valid and s1_addr3 equals addr1 (addr2), operand A (B) takes the stage-2 result, not RF contents; both operands forward independently.
REQ-022 ADD: {carry, result} = A + B over DATA_W+1 bits; result is low DATA_W bits (wraps modulo 2^DATA_W).
REQ-023 SUB: result = A - B modulo 2^DATA_W; wb_carry = 1 iff A < B unsigned.
REQ-024 AND/OR: bitwise; wb_carry = 0.
REQ-025 addr1, addr2, addr3 may alias; same-register sources and self-destination are legal.
REQ-026 All 32 registers writable; no hard-wired zero register.
REQ-027 retired increments by 1 at each E2 write, wraps 0xFFFF -> 0x0000.
REQ-028 Inputs with in_valid=0 are ignored (no RF, counter, or wb change beyond wb_valid=0).

Reset
REQ-029 rstN=0 sampled at a rising edge: RF[i] = i (truncated to DATA_W), s1_valid=0, wb_valid=0, wb_addr=0, wb_data=0, wb_carry=0, retired=0.
REQ-030 Reset mid-operation discards any instruction in stage 1; no write-back for it after reset releases.
REQ-031 Reset overrides in_valid in the same cycle; first instruction accepted at the first edge with rstN=1.

Verification
REQ-032 Reset, then ADD addr1=3 addr2=4 addr3=10 -> two cycles later wb_valid=1, wb_addr=10, wb_data=7, wb_carry=0, retired=1, dbg_data(10)=7.
REQ-033 Back-to-back: ADD r1+r2->r5, then next cycle ADD r5+r5->r6 -> r5=3, r6=6 (forwarding), wb_valid high two consecutive cycles.
REQ-034 SUB r2-r7->r8 (DATA_W=8) -> wb_data=0xFB, wb_carry=1; ADD with r9 previously set to 0xFF plus r1 -> wb_data=0x00, wb_carry=1.
REQ-035 AND r12&r10->r0, OR r12|r3->r1 -> r0=8, r1=15, wb_carry=0 both.
REQ-036 in_valid toggling 1,0,1 -> wb_valid pattern 1,0,1 two cycles later; retired=2; RF unchanged by the idle slot.
REQ-037 Assert rstN=0 one cycle after issuing an ADD -> no write-back, destination holds reset value i, retired=0.

Source files
------------

// File: rtl/exec_unit.sv
// Two-stage register-file execute unit: stage 1 captures operands with forwarding,
// stage 2 computes ADD/SUB/AND/OR and writes the result back to the register file.
module exec_unit #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RF_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              in_valid,
    input  logic [1:0]        op,
    input  logic [4:0]        addr1,
    input  logic [4:0]        addr2,
    input  logic [4:0]        addr3,
    output logic              wb_valid,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_carry,
    output logic [15:0]       retired,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned AW    = 5;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    // Register file and its reset image (entry i resets to i).
    logic [DATA_W-1:0] rf_q   [RF_DEPTH];
    logic [DATA_W-1:0] rf_d   [RF_DEPTH];
    logic [DATA_W-1:0] rf_rst [RF_DEPTH];

    for (genvar g = 0; g < RF_DEPTH; g++) begin : g_rf_rst
        assign rf_rst[g] = DATA_W'(g);
    end

    // Stage-1 registers.
    logic              s1_valid_q, s1_valid_d;
    logic [1:0]        s1_op_q,    s1_op_d;
    logic [AW-1:0]     s1_addr3_q, s1_addr3_d;
    logic [DATA_W-1:0] s1_a_q,     s1_a_d;
    logic [DATA_W-1:0] s1_b_q,     s1_b_d;

    // Write-back registers.
    logic              wb_valid_q, wb_valid_d;
    logic [AW-1:0]     wb_addr_q,  wb_addr_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;
    logic              wb_carry_q, wb_carry_d;
    logic [CNT_W-1:0]  retired_q,  retired_d;

    // Stage-2 ALU results.
    logic [DATA_W:0]   ext_a;
    logic [DATA_W:0]   ext_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;

    // Stage-2 ALU; SUB borrow falls out as the top bit of the widened difference.
    always_comb begin
        ext_a     = {1'b0, s1_a_q};
        ext_b     = {1'b0, s1_b_q};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (s1_op_q)
            OP_ADD:  {alu_carry, alu_res} = ext_a + ext_b;
            OP_SUB:  {alu_carry, alu_res} = ext_a - ext_b;
            OP_AND:  alu_res = s1_a_q & s1_b_q;
            default: alu_res = s1_a_q | s1_b_q;
        endcase
    end

    // Stage-1 capture; the in-flight result bypasses the RF write happening at the same edge.
    always_comb begin
        s1_valid_d = in_valid;
        s1_op_d    = s1_op_q;
        s1_addr3_d = s1_addr3_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (in_valid) begin
            s1_op_d    = op;
            s1_addr3_d = addr3;
            s1_a_d     = (s1_valid_q && (s1_addr3_q == addr1)) ? alu_res : rf_q[addr1];
            s1_b_d     = (s1_valid_q && (s1_addr3_q == addr2)) ? alu_res : rf_q[addr2];
        end
    end

    // Stage-2 write-back into the RF and the observable wb_* registers.
    always_comb begin
        rf_d       = rf_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_carry_d = wb_carry_q;
        retired_d  = retired_q;
        if (s1_valid_q) begin
            rf_d[s1_addr3_q] = alu_res;
            wb_valid_d       = 1'b1;
            wb_addr_d        = s1_addr3_q;
            wb_data_d        = alu_res;
            wb_carry_d       = alu_carry;
            retired_d        = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            rf_q       <= rf_rst;
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_addr3_q <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_carry_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            rf_q       <= rf_d;
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_addr3_q <= s1_addr3_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_carry_q <= wb_carry_d;
            retired_q  <= retired_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign wb_carry = wb_carry_q;
    assign retired  = retired_q;
    assign dbg_data = rf_q[dbg_addr];

endmodule
